// File: rtl/draw_cmd_scheduler_pkg.sv
// Shared graphics command codes, widths and scheduler state encoding for the
// draw-unit front end.
package draw_cmd_scheduler_pkg;

    localparam int CMD_W   = 8;
    localparam int DATA_W  = 256;
    localparam int ENTRY_W = CMD_W + DATA_W;

    localparam logic [7:0] CMD_NOP  = 8'h00;
    localparam logic [7:0] CMD_LINE = 8'h01;
    localparam logic [7:0] CMD_RECT = 8'h02;
    localparam logic [7:0] CMD_BLIT = 8'h03;
    localparam logic [7:0] CMD_FLIP = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_FLIP_WAIT = 3'd3,
        S_FLIP      = 3'd4
    } sched_state_t;

    // Next frame-buffer bank, wrapping at num_banks.
    function automatic logic [1:0] next_bank(input logic [1:0] bank, input int num_banks);
        if (int'(bank) >= num_banks - 1) begin
            return 2'd0;
        end else begin
            return bank + 2'd1;
        end
    endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO for queued draw commands; pointers
// carry one extra wrap bit so full and empty are distinguishable.
module draw_cmd_fifo
    import draw_cmd_scheduler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = ENTRY_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [W-1:0] mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;

    // Storage write; a full FIFO drops the write.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Read and write pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en && !empty) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign count   = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/draw_cmd_scheduler.sv
// Draw command scheduler: round-robin intake from two requesters into a FIFO,
// one-at-a-time dispatch to the draw unit, and FLIP frame-buffer bank swaps.
module draw_cmd_scheduler
    import draw_cmd_scheduler_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int NUM_BANKS = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [7:0]   req0_command,
    input  logic [255:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [7:0]   req1_command,
    input  logic [255:0] req1_data,
    output logic         req1_ready,
    output logic [7:0]   du_command,
    output logic [255:0] du_data,
    output logic         du_commit,
    input  logic         du_ack,
    input  logic         du_done,
    output logic [1:0]   draw_bank,
    output logic [1:0]   display_bank,
    output logic         flip_done,
    output logic [AW:0]  fifo_count,
    output logic         busy
);
    sched_state_t       state_r;
    sched_state_t       state_next_s;
    logic               rr_r;
    logic               grant0_s;
    logic               grant1_s;
    logic               wr_en_s;
    logic [ENTRY_W-1:0] wr_data_s;
    logic [ENTRY_W-1:0] head_s;
    logic               full_s;
    logic               empty_s;
    logic               head_is_flip_s;
    logic               pop_s;
    logic               flip_s;
    logic [7:0]         du_command_r;
    logic [255:0]       du_data_r;
    logic               du_commit_r;
    logic [1:0]         draw_bank_r;
    logic [1:0]         display_bank_r;
    logic               flip_done_r;

    // Round-robin grant; rr_r set means req1 was not served last and wins a tie.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && (!req1_valid || !rr_r)) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign req0_ready = grant0_s && !full_s;
    assign req1_ready = grant1_s && !full_s;
    assign wr_en_s    = req0_ready || req1_ready;
    assign wr_data_s  = grant0_s ? {req0_command, req0_data} : {req1_command, req1_data};

    // Round-robin pointer moves away from whoever was just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r <= 1'b0;
        end else if (req0_ready) begin
            rr_r <= 1'b1;
        end else if (req1_ready) begin
            rr_r <= 1'b0;
        end
    end

    draw_cmd_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .W    (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en_s),
        .wr_data(wr_data_s),
        .rd_en  (pop_s),
        .rd_data(head_s),
        .full   (full_s),
        .empty  (empty_s),
        .count  (fifo_count)
    );

    assign head_is_flip_s = (head_s[ENTRY_W-1 -: CMD_W] == CMD_FLIP);

    // Dispatch state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Dispatch next-state and pop/flip strobes.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        flip_s       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = head_is_flip_s ? S_FLIP_WAIT : S_ISSUE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (du_commit_r && du_ack) begin
                    state_next_s = S_WAIT_DONE;
                end else begin
                    state_next_s = S_ISSUE;
                end
            end
            S_WAIT_DONE: begin
                if (du_done) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_WAIT_DONE;
                end
            end
            S_FLIP_WAIT: begin
                if (du_ack) begin
                    state_next_s = S_FLIP;
                end else begin
                    state_next_s = S_FLIP_WAIT;
                end
            end
            S_FLIP: begin
                flip_s       = 1'b1;
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Draw-unit command registers, commit strobe, banks and flip pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            du_command_r   <= 8'h00;
            du_data_r      <= 256'd0;
            du_commit_r    <= 1'b0;
            draw_bank_r    <= 2'd0;
            display_bank_r <= 2'd1;
            flip_done_r    <= 1'b0;
        end else begin
            du_commit_r <= (state_next_s == S_ISSUE);
            flip_done_r <= flip_s;
            if (pop_s && !head_is_flip_s) begin
                du_command_r <= head_s[ENTRY_W-1 -: CMD_W];
                du_data_r    <= head_s[DATA_W-1:0];
            end
            if (flip_s) begin
                display_bank_r <= draw_bank_r;
                draw_bank_r    <= next_bank(draw_bank_r, NUM_BANKS);
            end
        end
    end

    assign du_command   = du_command_r;
    assign du_data      = du_data_r;
    assign du_commit    = du_commit_r;
    assign draw_bank    = draw_bank_r;
    assign display_bank = display_bank_r;
    assign flip_done    = flip_done_r;
    assign busy         = !empty_s || (state_r != S_IDLE);

endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Scoreboard bench for draw_cmd_scheduler: directed scenarios plus a random
// phase, with a behavioural draw-unit responder and an ordering/bank model.
module tb_draw_cmd_scheduler;
    import draw_cmd_scheduler_pkg::*;

    localparam int DEPTH = 8;
    localparam logic [255:0] RECT_DATA = 256'hF8000A0A000000;

    typedef struct packed {
        logic [7:0]   cmd;
        logic [255:0] data;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [7:0]   req0_command, req1_command;
    logic [255:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic [7:0]   du_command;
    logic [255:0] du_data;
    logic         du_commit, du_ack, du_done;
    logic [1:0]   draw_bank, display_bank;
    logic         flip_done;
    logic [3:0]   fifo_count;
    logic         busy;

    int   errors = 0;
    int   checks = 0;
    ent_t exp_q[$];
    logic rr_m;
    int   m_draw, m_disp;
    logic stall, rand_delays, du_busy, du_hs;
    int   fix_delay, du_cnt;

    draw_cmd_scheduler #(.DEPTH(DEPTH), .AW(3), .NUM_BANKS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_command(req0_command), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_command(req1_command), .req1_data(req1_data), .req1_ready(req1_ready),
        .du_command(du_command), .du_data(du_data), .du_commit(du_commit),
        .du_ack(du_ack), .du_done(du_done),
        .draw_bank(draw_bank), .display_bank(display_bank), .flip_done(flip_done),
        .fifo_count(fifo_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [263:0] got, input logic [263:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected / bound expired", name);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [7:0] rnd_cmd();
        if ($urandom_range(0, 7) == 0) return CMD_FLIP;
        else return 8'($urandom_range(0, 254));
    endfunction

    // Present one cycle of requests; predict the grant and record accepted entries.
    task automatic drive(input logic v0, input logic [7:0] c0, input logic [255:0] d0,
                         input logic v1, input logic [7:0] c1, input logic [255:0] d1,
                         input bit chk_en, input bit exp_full, output bit acc);
        logic g0, g1;
        ent_t e;
        @(negedge clk);
        req0_valid = v0; req0_command = c0; req0_data = d0;
        req1_valid = v1; req1_command = c1; req1_data = d1;
        #1;
        g0 = v0 && (!v1 || !rr_m);
        g1 = v1 && !g0;
        if (chk_en) begin
            chk("ready0", req0_ready, g0 && !exp_full);
            chk("ready1", req1_ready, g1 && !exp_full);
        end
        acc = 1'b0;
        if (req0_ready) begin
            e.cmd = c0; e.data = d0; exp_q.push_back(e); rr_m = 1'b1; acc = 1'b1;
        end else if (req1_ready) begin
            e.cmd = c1; e.data = d1; exp_q.push_back(e); rr_m = 1'b0; acc = 1'b1;
        end
    endtask

    task automatic quiet();
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Wait for every expected command to complete, then expect an idle scheduler.
    task automatic drain(input string name);
        int n;
        n = 0;
        stall = 1'b0;
        do begin
            @(negedge clk); #4;
            n++;
        end while ((exp_q.size() != 0 || du_busy || du_done || du_hs) && n < 3000);
        if (n >= 3000) fail({name, "_timeout"});
        repeat (2) @(negedge clk);
        #3;
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_count"}, fifo_count, 4'd0);
    endtask

    // Behavioural draw unit: idle => du_ack follows !stall; after a handshake it
    // is busy for a delay (frozen while stalled), then pulses du_done once.
    initial begin
        du_ack = 1'b0; du_done = 1'b0; du_busy = 1'b0; du_hs = 1'b0; du_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                du_ack = 1'b0; du_done = 1'b0; du_busy = 1'b0; du_hs = 1'b0;
            end else begin
                du_done = 1'b0;
                if (du_hs) begin
                    du_busy = 1'b1;
                    du_cnt  = rand_delays ? int'($urandom_range(0, 3)) : fix_delay;
                end
                if (du_busy) begin
                    du_ack = 1'b0;
                    if (stall || du_cnt > 0) begin
                        if (!stall) du_cnt--;
                    end else begin
                        du_done = 1'b1;
                        du_busy = 1'b0;
                    end
                end else begin
                    du_ack = !stall;
                end
                du_hs = du_ack && du_commit;
            end
        end
    end

    // Monitor: each dispatch handshake and each flip pulse consumes the oldest expected entry.
    initial begin
        ent_t e;
        int nd, np;
        m_draw = 0; m_disp = 1;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                m_draw = 0; m_disp = 1;
            end else begin
                if (du_commit && du_ack) begin
                    if (exp_q.size() == 0) fail("dispatch_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        chk("dispatch", {du_command, du_data}, {e.cmd, e.data});
                    end
                end
                if (flip_done) begin
                    if (exp_q.size() == 0) fail("flip_unexpected");
                    else begin
                        e = exp_q.pop_front();
                        chk("flip_order", e.cmd, CMD_FLIP);
                        nd = (m_draw + 1) % 2;
                        np = m_draw;
                        chk("flip_draw_bank", draw_bank, nd);
                        chk("flip_display_bank", display_bank, np);
                        chk("flip_du_idle", du_busy, 1'b0);
                        m_draw = nd; m_disp = np;
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic v0, v1;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_command = 8'h00; req0_data = '0;
        req1_valid = 1'b0; req1_command = 8'h00; req1_data = '0;
        stall = 1'b0; rand_delays = 1'b0; fix_delay = 1; rr_m = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_commit", du_commit, 1'b0);
        chk("rst_command", du_command, 8'h00);
        chk("rst_data", du_data, 256'd0);
        chk("rst_draw_bank", draw_bank, 2'd0);
        chk("rst_display_bank", display_bank, 2'd1);
        chk("rst_flip_done", flip_done, 1'b0);
        chk("rst_count", fifo_count, 4'd0);
        chk("rst_busy", busy, 1'b0);
        #1 rst_n = 1'b1;

        // Single RECT: commit two cycles after the accepting cycle.
        drive(1'b1, CMD_RECT, RECT_DATA, 1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
        quiet(); #3;
        chk("single_commit_early", du_commit, 1'b0);
        @(negedge clk); #3;
        chk("single_commit", du_commit, 1'b1);
        chk("single_data", du_data, RECT_DATA);
        drain("single");

        // du_done in the first cycle after the handshake.
        fix_delay = 0;
        drive(1'b1, CMD_LINE, rnd256(), 1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
        quiet();
        drain("done_ack");
        fix_delay = 1;

        // Contention behind a stalled command taken from req1.
        stall = 1'b1;
        drive(1'b0, 8'h00, '0, 1'b1, CMD_BLIT, rnd256(), 1'b1, 1'b0, acc);
        quiet();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h10 + i), rnd256(), 1'b1, 8'(8'h20 + i), rnd256(), 1'b1, 1'b0, acc);
            chk("contend_alt0", req0_ready, (i % 2) == 0);
            chk("contend_alt1", req1_ready, (i % 2) == 1);
        end
        quiet(); #3;
        chk("contend_count", fifo_count, 4'd4);
        drain("contend");

        // Full FIFO: one command parked in ISSUE, eight queued, ninth refused.
        stall = 1'b1;
        drive(1'b1, CMD_RECT, rnd256(), 1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
        for (int i = 0; i < 8; i++)
            drive(1'b1, 8'(8'h30 + i), rnd256(), 1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
        drive(1'b1, 8'h40, RECT_DATA, 1'b0, 8'h00, '0, 1'b1, 1'b1, acc);
        chk("full_count", fifo_count, 4'd8);
        stall = 1'b0;
        acc = 1'b0;
        for (int i = 0; i < 30 && !acc; i++)
            drive(1'b1, 8'h40, RECT_DATA, 1'b0, 8'h00, '0, 1'b0, 1'b0, acc);
        chk("full_accept_later", acc, 1'b1);
        quiet();
        drain("full");

        // RECT, FLIP, RECT, then a second FLIP returning the banks.
        drive(1'b1, CMD_RECT, rnd256(), 1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
        drive(1'b1, CMD_FLIP, rnd256(), 1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
        drive(1'b1, CMD_RECT, rnd256(), 1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
        quiet();
        drain("flip1");
        chk("flip1_draw", draw_bank, 2'd1);
        chk("flip1_display", display_bank, 2'd0);
        drive(1'b0, 8'h00, '0, 1'b1, CMD_FLIP, '0, 1'b1, 1'b0, acc);
        quiet();
        drain("flip2");
        chk("flip2_draw", draw_bank, 2'd0);
        chk("flip2_display", display_bank, 2'd1);

        // Random traffic with random draw-unit latency and stalls.
        rand_delays = 1'b1;
        for (int i = 0; i < 600; i++) begin
            stall = ($urandom_range(0, 5) == 0);
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (exp_q.size() >= DEPTH) begin
                v0 = 1'b0; v1 = 1'b0;
            end
            drive(v0, rnd_cmd(), rnd256(), v1, rnd_cmd(), rnd256(), 1'b1, 1'b0, acc);
        end
        quiet();
        drain("random");

        // Reset while waiting for du_done with three entries queued.
        rand_delays = 1'b0; fix_delay = 50; stall = 1'b0;
        for (int i = 0; i < 4; i++)
            drive(1'b1, CMD_RECT, rnd256(), 1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
        quiet();
        repeat (3) @(negedge clk);
        #3;
        chk("pre_rst_count", fifo_count, 4'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_commit", du_commit, 1'b0);
        chk("midrst_count", fifo_count, 4'd0);
        chk("midrst_draw", draw_bank, 2'd0);
        chk("midrst_display", display_bank, 2'd1);
        chk("midrst_busy", busy, 1'b0);
        exp_q.delete();
        rr_m = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        fix_delay = 1;
        drive(1'b1, CMD_RECT, RECT_DATA, 1'b0, 8'h00, '0, 1'b1, 1'b0, acc);
        quiet();
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
